muldiv_sched: RTL and testbench

//  Sequences a shared iterative multiply/divide datapath for the RV32M ops issued in Execute.

---
 rtl/muldiv_sched_if.sv | 32 +++
 rtl/muldiv_sched.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// +--------------------------------------------------------------------------+
// | muldiv_sched_if : Execute-stage handshake between the pipeline and the   |
// |                   iterative RV32M multiply/divide sequencer.             |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

interface muldiv_sched_if #(
  parameter int XLEN = 32
);
  logic            start_E;
  logic [2:0]      op_E;
  logic [XLEN-1:0] a_E;
  logic [XLEN-1:0] b_E;
  logic            kill_E;
  logic            stall_md;
  logic            busy;
  logic            res_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start_E, op_E, a_E, b_E, kill_E,
    input  stall_md, busy, res_valid, result
  );

  modport slave (
    input  start_E, op_E, a_E, b_E, kill_E,
    output stall_md, busy, res_valid, result
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_sched.sv
// +--------------------------------------------------------------------------+
// | muldiv_sched : bit-serial RV32M multiply/divide sequencer with pipeline  |
// |                stall, kill and fast-path handling of divide specials.    |
// | Option       : MD_EARLY_OUT_EN enables multiply early termination.       |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_sched #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_sched_if.slave  md
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic                spec_q, spec_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     opb_q, opb_d;

  // Issue-time decode
  logic              a_signed, b_signed, sa_in, sb_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              b_zero, ovf, special;
  logic [XLEN-1:0]   spec_res;

  assign a_signed = (md.op_E == 3'd1) || (md.op_E == 3'd2) ||
                    (md.op_E == 3'd4) || (md.op_E == 3'd6);
  assign b_signed = (md.op_E == 3'd1) || (md.op_E == 3'd4) || (md.op_E == 3'd6);
  assign sa_in    = a_signed & md.a_E[XLEN-1];
  assign sb_in    = b_signed & md.b_E[XLEN-1];
  assign mag_a    = sa_in ? -md.a_E : md.a_E;
  assign mag_b    = sb_in ? -md.b_E : md.b_E;
  assign b_zero   = (md.b_E == '0);
  assign ovf      = ((md.op_E == 3'd4) || (md.op_E == 3'd6)) &&
                    (md.a_E == {1'b1, {(XLEN-1){1'b0}}}) && (md.b_E == '1);

`ifdef MD_EARLY_OUT_EN
  assign special  = (md.op_E[2] & (b_zero | ovf)) | (~md.op_E[2] & b_zero);
`else
  assign special  = md.op_E[2] & (b_zero | ovf);
`endif

  always_comb begin
    spec_res = '0;
    if (md.op_E[2]) begin
      if (b_zero)   spec_res = md.op_E[1] ? md.a_E : '1;
      else if (ovf) spec_res = md.op_E[1] ? '0 : md.a_E;
    end
  end

  // Restoring divide step: acc holds {remainder, dividend/quotient}
  logic [XLEN:0]     rem_sh, diff;
  logic [2*XLEN-1:0] div_next;

  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff     = rem_sh - {1'b0, opb_q};
  assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    spec_d  = spec_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opb_d   = opb_q;

    case (state_q)
      S_IDLE: begin
        if (md.start_E && !md.kill_E) begin
          op_d = md.op_E;
          sa_d = sa_in;
          sb_d = sb_in;
          if (special) begin
            spec_d  = 1'b1;
            acc_d   = {{XLEN{1'b0}}, spec_res};
            state_d = S_DONE;
          end else begin
            spec_d  = 1'b0;
            cnt_d   = CNT_W'(XLEN);
            opb_d   = mag_b;
            state_d = S_CALC;
            if (md.op_E[2]) begin
              acc_d   = {{XLEN{1'b0}}, mag_a};
              mcand_d = '0;
            end else begin
              acc_d   = '0;
              mcand_d = {{XLEN{1'b0}}, mag_a};
            end
          end
        end
      end

      S_CALC: begin
        if (md.kill_E) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (op_q[2]) begin
            acc_d = div_next;
          end else begin
            acc_d   = opb_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
          end
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
`ifdef MD_EARLY_OUT_EN
          // Multiplicand is pre-shifted, so the partial product is already in place
          if (!op_q[2] && (opb_q[XLEN-1:1] == '0)) state_d = S_DONE;
`endif
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      spec_q  <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      spec_q  <= spec_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      opb_q   <= opb_d;
    end
  end

  // Sign fixup on the magnitude result
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fin = '0;
    if (spec_q) begin
      fin = acc_q[XLEN-1:0];
    end else begin
      case (op_q)
        3'd0:                 fin = prod[XLEN-1:0];
        3'd1, 3'd2, 3'd3:     fin = prod[2*XLEN-1:XLEN];
        3'd4, 3'd5:           fin = quo;
        default:              fin = rem;
      endcase
    end
  end

  assign md.busy      = (state_q != S_IDLE);
  assign md.res_valid = (state_q == S_DONE);
  assign md.result    = md.res_valid ? fin : '0;
  assign md.stall_md  = ((state_q == S_IDLE) & md.start_E & ~md.kill_E) |
                        ((state_q == S_CALC) & ~md.kill_E);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sched.sv
// +--------------------------------------------------------------------------+
// | tb_muldiv_sched : directed self-checking bench for muldiv_sched.         |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_sched;
  localparam int XLEN = 32;

`ifdef MD_EARLY_OUT_EN
  localparam int LAT_MUL1 = 2;
  localparam int LAT_MUL0 = 1;
`else
  localparam int LAT_MUL1 = 33;
  localparam int LAT_MUL0 = 33;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sched_if #(.XLEN(XLEN)) md ();

  muldiv_sched #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the issue cycle; returns cycles with stall_md high and res_valid cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int lat, output logic [31:0] res);
    bit done;
    done   = 1'b0;
    stalls = 0;
    lat    = -1;
    res    = 'x;
    @(negedge clk);
    md.start_E = 1'b1;
    md.op_E    = op;
    md.a_E     = a;
    md.b_E     = b;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (md.stall_md) stalls++;
      if (md.res_valid) begin
        lat  = c;
        res  = md.result;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    md.start_E = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int stalls, lat;
    logic [31:0] res;
    run_op(op, a, b, stalls, lat, res);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rv_seen;
    md.start_E = 1'b0;
    md.op_E    = 3'd0;
    md.a_E     = '0;
    md.b_E     = '0;
    md.kill_E  = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", md.stall_md, 0);
    check("rst_busy", md.busy, 0);
    check("rst_res_valid", md.res_valid, 0);
    check("rst_result", md.result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul_7xm3",     3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("mulhu_ff",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulh_ff",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    do_op("mulhsu_m2x3",  3'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
    do_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu_100_0",   3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("remu_100_0",   3'd7, 32'd100, 32'd0, 32'd100, 1);
    do_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Kill in the tenth CALC cycle
    @(negedge clk);
    md.start_E = 1'b1;
    md.op_E    = 3'd5;
    md.a_E     = 32'd50;
    md.b_E     = 32'd7;
    repeat (10) @(negedge clk);
    md.kill_E = 1'b1;
    #1;
    check("kill_busy_before", md.busy, 1);
    check("kill_stall_drop", md.stall_md, 0);
    @(negedge clk);
    md.kill_E  = 1'b0;
    md.start_E = 1'b0;
    #1;
    check("kill_busy_after", md.busy, 0);
    rv_seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      #1;
      if (md.res_valid) rv_seen = 1'b1;
    end
    check("kill_no_res_valid", rv_seen, 0);
    do_op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 33);

    // Back-to-back: second issue lands in the single IDLE cycle after DONE
    do_op("b2b_mul_7x3", 3'd0, 32'd7, 32'd3, 32'h15, 33);
    do_op("b2b_remu_10_3", 3'd7, 32'd10, 32'd3, 32'd1, 33);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    md.start_E = 1'b1;
    md.op_E    = 3'd0;
    md.a_E     = 32'd3;
    md.b_E     = 32'd4;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_busy_before", md.busy, 1);
    rst_n      = 1'b0;
    md.start_E = 1'b0;
    #1;
    check("midrst_stall", md.stall_md, 0);
    check("midrst_busy", md.busy, 0);
    check("midrst_res_valid", md.res_valid, 0);
    check("midrst_result", md.result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul_5x1", 3'd0, 32'd5, 32'd1, 32'd5, LAT_MUL1);
    do_op("mul_9x0", 3'd0, 32'd9, 32'd0, 32'd0, LAT_MUL0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
